// File: rtl/pwm_breath_ramp_if.sv
// rtl/pwm_breath_ramp_if.sv - enable/duty/strobe bundle between breathing sequencer and PWM stage
interface pwm_breath_ramp_if #(
  parameter int N = 4
);
  logic         i_en;
  logic [N-1:0] o_duty;
  logic         o_period_start;
  logic [2:0]   o_state;

  // controller side: drives the run enable, observes the duty profile
  modport master (
    output i_en,
    input  o_duty,
    input  o_period_start,
    input  o_state
  );

  // sequencer side
  modport slave (
    input  i_en,
    output o_duty,
    output o_period_start,
    output o_state
  );
endinterface

// File: rtl/pwm_breath_ramp.sv
// rtl/pwm_breath_ramp.sv - breathing-profile duty sequencer owning the PWM period timebase
module pwm_breath_ramp #(
  parameter int PERIOD = 10,
  parameter int N      = 4,
  parameter int STEP   = 2,
  parameter int REPEAT = 2,
  parameter int HOLD   = 3
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  pwm_breath_ramp_if.slave  bus
);

  localparam int RW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [N-1:0]  PERIOD_M1  = N'(PERIOD - 1);
  localparam logic [N-1:0]  PERIOD_N   = N'(PERIOD);
  localparam logic [N:0]    PERIOD_X   = (N+1)'(PERIOD);
  localparam logic [N:0]    STEP_X     = (N+1)'(STEP);
  localparam logic [N-1:0]  FIRST_DUTY = (STEP > PERIOD) ? N'(PERIOD) : N'(STEP);
  localparam logic [RW-1:0] REPEAT_M1  = RW'(REPEAT - 1);
  localparam logic [HW-1:0] HOLD_M1    = HW'(HOLD - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RISE    = 3'd1,
    HOLD_HI = 3'd2,
    FALL    = 3'd3,
    HOLD_LO = 3'd4
  } state_t;

  state_t        state;
  logic [N-1:0]  period_cnt;
  logic [RW-1:0] rep_cnt;
  logic [HW-1:0] hold_cnt;
  logic [N-1:0]  duty;
  logic          period_start;

  logic [N:0]    up_sum;
  logic [N:0]    dn_diff;
  logic [N-1:0]  duty_up;
  logic [N-1:0]  duty_dn;

  // Next ramp values, one bit wider so the saturation test sees the true result
  always_comb begin
    up_sum  = {1'b0, duty} + STEP_X;
    dn_diff = {1'b0, duty} - STEP_X;
    duty_up = (up_sum > PERIOD_X) ? PERIOD_N : up_sum[N-1:0];
    duty_dn = dn_diff[N] ? '0 : dn_diff[N-1:0];
  end

  // Timebase and profile FSM; duty/state only move on the period wrap edge
  always_ff @(posedge sys_clk) begin
    if (sys_rst || !bus.i_en) begin
      state        <= IDLE;
      period_cnt   <= '0;
      rep_cnt      <= '0;
      hold_cnt     <= '0;
      duty         <= '0;
      period_start <= 1'b0;
    end else if (state == IDLE) begin
      state        <= RISE;
      period_cnt   <= '0;
      rep_cnt      <= '0;
      hold_cnt     <= '0;
      duty         <= '0;
      period_start <= 1'b1;
    end else if (period_cnt != PERIOD_M1) begin
      period_cnt   <= period_cnt + 1'b1;
      period_start <= 1'b0;
    end else begin
      period_cnt   <= '0;
      period_start <= 1'b1;
      case (state)
        RISE: begin
          if (rep_cnt == REPEAT_M1) begin
            rep_cnt <= '0;
            duty    <= duty_up;
            if (duty_up == PERIOD_N) begin
              state    <= HOLD_HI;
              hold_cnt <= '0;
            end
          end else begin
            rep_cnt <= rep_cnt + 1'b1;
          end
        end
        HOLD_HI: begin
          if (hold_cnt == HOLD_M1) begin
            duty     <= duty_dn;
            rep_cnt  <= '0;
            hold_cnt <= '0;
            state    <= (duty_dn == '0) ? HOLD_LO : FALL;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        FALL: begin
          if (rep_cnt == REPEAT_M1) begin
            rep_cnt <= '0;
            duty    <= duty_dn;
            if (duty_dn == '0) begin
              state    <= HOLD_LO;
              hold_cnt <= '0;
            end
          end else begin
            rep_cnt <= rep_cnt + 1'b1;
          end
        end
        HOLD_LO: begin
          if (hold_cnt == HOLD_M1) begin
            duty     <= FIRST_DUTY;
            rep_cnt  <= '0;
            hold_cnt <= '0;
            state    <= (FIRST_DUTY == PERIOD_N) ? HOLD_HI : RISE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_duty         = duty;
  assign bus.o_period_start = period_start;
  assign bus.o_state        = state;

endmodule

// File: tb/tb_pwm_breath_ramp.sv
// tb/tb_pwm_breath_ramp.sv - scoreboard bench for the breathing duty sequencer
module tb_pwm_breath_ramp;

  typedef struct packed {
    logic [3:0] duty;
    logic [2:0] state;
  } exp_t;

  logic sys_clk;
  logic sys_rst;
  int   sel;
  int   n_cmp;
  int   n_fail;
  exp_t exp_q[$];

  logic [3:0] mon_duty;
  logic       mon_strobe;
  logic [2:0] mon_state;

  pwm_breath_ramp_if #(.N(4)) bus0 ();
  pwm_breath_ramp_if #(.N(4)) bus1 ();
  pwm_breath_ramp_if #(.N(4)) bus2 ();

  pwm_breath_ramp #(.PERIOD(10), .N(4), .STEP(2), .REPEAT(2), .HOLD(3)) u_dut0 (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus0)
  );

  pwm_breath_ramp #(.PERIOD(10), .N(4), .STEP(3), .REPEAT(1), .HOLD(1)) u_dut1 (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus1)
  );

  pwm_breath_ramp #(.PERIOD(10), .N(4), .STEP(10), .REPEAT(1), .HOLD(2)) u_dut2 (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus2)
  );

  assign mon_duty   = (sel == 0) ? bus0.o_duty : (sel == 1) ? bus1.o_duty : bus2.o_duty;
  assign mon_strobe = (sel == 0) ? bus0.o_period_start :
                      (sel == 1) ? bus1.o_period_start : bus2.o_period_start;
  assign mon_state  = (sel == 0) ? bus0.o_state : (sel == 1) ? bus1.o_state : bus2.o_state;

  int def_duty [26] = '{0,0,2,2,4,4,6,6,8,8,10,10,10,8,8,6,6,4,4,2,2,0,0,0,2,2};
  int def_state[26] = '{1,1,1,1,1,1,1,1,1,1,2,2,2,3,3,3,3,3,3,3,3,4,4,4,1,1};
  int s3_duty  [10] = '{0,3,6,9,10,7,4,1,0,3};
  int s3_state [10] = '{1,1,1,1,2,3,3,3,4,1};
  int s10_duty [7]  = '{0,10,10,0,0,10,10};
  int s10_state[7]  = '{1,2,2,4,4,2,2};

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int d, input int s);
    exp_t e;
    e.duty  = 4'(d);
    e.state = 3'(s);
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drain(input int limit);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < limit) begin
      tick();
      g++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d strobes still outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: pops an expectation on every strobe, checks period spacing and mid-period stability
  initial begin : monitor
    exp_t       e;
    logic [2:0] prev_state;
    logic [3:0] cur_duty;
    logic [2:0] cur_state;
    int         since;
    prev_state = 3'd0;
    cur_duty   = 4'd0;
    cur_state  = 3'd0;
    since      = 0;
    forever begin
      @(negedge sys_clk);
      since++;
      if (mon_strobe === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_strobe: strobe seen with duty %0d state %0d, expected none", mon_duty, mon_state);
        end else begin
          e = exp_q.pop_front();
          check("strobe_duty", 8'(mon_duty), 8'(e.duty));
          check("strobe_state", 8'(mon_state), 8'(e.state));
          cur_duty  = e.duty;
          cur_state = e.state;
        end
        if (prev_state != 3'd0) check("strobe_spacing", 8'(since), 8'd10);
        since = 0;
      end else if (mon_state !== 3'd0 && prev_state != 3'd0) begin
        check("mid_period_duty", 8'(mon_duty), 8'(cur_duty));
        check("mid_period_state", 8'(mon_state), 8'(cur_state));
      end else if (mon_state === 3'd0) begin
        check("idle_duty", 8'(mon_duty), 8'd0);
      end
      prev_state = mon_state;
    end
  end

  // Stimulus: directed scenarios, expectations queued before each enable
  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    sel       = 0;
    sys_rst   = 1'b1;
    bus0.i_en = 1'b0;
    bus1.i_en = 1'b0;
    bus2.i_en = 1'b0;
    repeat (3) tick();

    check("reset_duty", 8'(bus0.o_duty), 8'd0);
    check("reset_strobe", 8'(bus0.o_period_start), 8'd0);
    check("reset_state", 8'(bus0.o_state), 8'd0);
    sys_rst = 1'b0;
    tick();
    check("idle_without_en", 8'(bus0.o_state), 8'd0);

    // full default profile
    for (int i = 0; i < 26; i++) push(def_duty[i], def_state[i]);
    bus0.i_en = 1'b1;
    tick();
    check("first_strobe", 8'(bus0.o_period_start), 8'd1);
    check("first_duty", 8'(bus0.o_duty), 8'd0);
    check("first_state", 8'(bus0.o_state), 8'd1);
    drain(400);
    bus0.i_en = 1'b0;
    tick();
    check("en_drop_state", 8'(bus0.o_state), 8'd0);
    repeat (2) tick();

    // drop enable mid-period 7, then re-enable from scratch
    for (int i = 0; i < 8; i++) push(def_duty[i], def_state[i]);
    bus0.i_en = 1'b1;
    drain(200);
    repeat (3) tick();
    check("pre_drop_duty", 8'(bus0.o_duty), 8'd6);
    bus0.i_en = 1'b0;
    tick();
    check("drop_state", 8'(bus0.o_state), 8'd0);
    check("drop_duty", 8'(bus0.o_duty), 8'd0);
    check("drop_strobe", 8'(bus0.o_period_start), 8'd0);
    repeat (30) tick();
    for (int i = 0; i < 3; i++) push(def_duty[i], def_state[i]);
    bus0.i_en = 1'b1;
    drain(100);
    bus0.i_en = 1'b0;
    repeat (2) tick();

    // reset during HOLD_HI with enable held
    for (int i = 0; i < 12; i++) push(def_duty[i], def_state[i]);
    bus0.i_en = 1'b1;
    drain(300);
    check("in_hold_hi", 8'(bus0.o_state), 8'd2);
    sys_rst = 1'b1;
    tick();
    check("rst_duty", 8'(bus0.o_duty), 8'd0);
    check("rst_strobe", 8'(bus0.o_period_start), 8'd0);
    check("rst_state", 8'(bus0.o_state), 8'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_held_state", 8'(bus0.o_state), 8'd0);
    end
    for (int i = 0; i < 3; i++) push(def_duty[i], def_state[i]);
    sys_rst = 1'b0;
    tick();
    check("rst_release_strobe", 8'(bus0.o_period_start), 8'd1);
    check("rst_release_state", 8'(bus0.o_state), 8'd1);
    drain(100);
    bus0.i_en = 1'b0;
    repeat (2) tick();

    // STEP=3, REPEAT=1, HOLD=1: clipping at both ends
    sel = 1;
    tick();
    for (int i = 0; i < 10; i++) push(s3_duty[i], s3_state[i]);
    bus1.i_en = 1'b1;
    drain(200);
    bus1.i_en = 1'b0;
    repeat (2) tick();

    // STEP=PERIOD, REPEAT=1, HOLD=2: ramps collapse straight into holds
    sel = 2;
    tick();
    for (int i = 0; i < 7; i++) push(s10_duty[i], s10_state[i]);
    bus2.i_en = 1'b1;
    drain(150);
    bus2.i_en = 1'b0;
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
